// File: rtl/usr_cmd_sequencer.sv
// usr_cmd_sequencer: queues shift-register commands in a small FIFO and plays
// each one out onto the register's mode/data_in/serial_in inputs for cnt+1
// consecutive cycles. Optional shadow model of the register contents is
// enabled by defining USR_SEQ_SHADOW_EN; otherwise shadow_q is tied to zero.
module usr_cmd_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_data,
  input  logic [7:0] cmd_sin,
  input  logic [2:0] cmd_cnt,
  output logic [1:0] mode,
  output logic [3:0] data_in,
  output logic       serial_in,
  output logic       busy,
  output logic       done,
  output logic [3:0] shadow_q
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] data;
    logic [7:0] sin;
    logic [2:0] cnt;
  } cmd_t;

  typedef enum logic {IDLE, EXEC} state_t;

  cmd_t        mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_n, rd_n;
  logic        empty, full, push, pop, load;
  cmd_t        head, cur, cur_n;
  state_t      state, state_n;
  logic [2:0]  step, step_n;
  logic [1:0]  mode_n;
  logic [3:0]  data_n;
  logic        sin_n, done_n, busy_n;

  // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready = !rst && !full;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr[AW-1:0]];

  // FIFO storage write; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{op: cmd_op, data: cmd_data, sin: cmd_sin, cnt: cmd_cnt};
  end

  // Next-state and registered-output values; a new command is loaded either
  // from IDLE or straight out of the final EXEC step so commands run back to back.
  always_comb begin
    state_n = state;
    cur_n   = cur;
    step_n  = step;
    mode_n  = '0;
    data_n  = '0;
    sin_n   = 1'b0;
    done_n  = 1'b0;
    pop     = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) load = 1'b1;
      end
      EXEC: begin
        if (step != cur.cnt) begin
          step_n = step + 3'd1;
          mode_n = cur.op;
          data_n = cur.data;
          sin_n  = cur.sin[step_n];
          done_n = (step_n == cur.cnt);
        end else if (!empty) begin
          load = 1'b1;
        end else begin
          state_n = IDLE;
          step_n  = '0;
        end
      end
    endcase
    if (load) begin
      pop     = 1'b1;
      cur_n   = head;
      step_n  = '0;
      state_n = EXEC;
      mode_n  = head.op;
      data_n  = head.data;
      sin_n   = head.sin[0];
      done_n  = (head.cnt == 3'd0);
    end
    wr_n   = wr_ptr + (AW+1)'(push);
    rd_n   = rd_ptr + (AW+1)'(pop);
    busy_n = (state_n == EXEC) || (wr_n != rd_n);
  end

  // State, pointer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= '0;
      step      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mode      <= '0;
      data_in   <= '0;
      serial_in <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cur       <= cur_n;
      step      <= step_n;
      wr_ptr    <= wr_n;
      rd_ptr    <= rd_n;
      mode      <= mode_n;
      data_in   <= data_n;
      serial_in <= sin_n;
      done      <= done_n;
      busy      <= busy_n;
    end
  end

`ifdef USR_SEQ_SHADOW_EN
  // Shadow register applies the step currently presented, mirroring the edge
  // at which the downstream shift register samples it.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
    end else if (state == EXEC) begin
      case (mode)
        2'b00: shadow_q <= shadow_q;
        2'b01: shadow_q <= {serial_in, shadow_q[3:1]};
        2'b10: shadow_q <= {shadow_q[2:0], serial_in};
        2'b11: shadow_q <= data_in;
      endcase
    end
  end
`else
  assign shadow_q = '0;
`endif

endmodule

// File: doc/usr_cmd_sequencer.md
# usr_cmd_sequencer

Command sequencer sitting directly upstream of the 4-bit universal shift register. Accepts queued shift-register commands over a valid/ready handshake, buffers them in a small FIFO, and drives the register's `mode`, `data_in` and `serial_in` inputs cycle by cycle, repeating each command a programmable number of times. An optional shadow model predicts the register contents for in-system checking.

## Interface
- `DEPTH`, 4, command FIFO entries; power of two, minimum 2.
- `clk` input 1 — sole clock, rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `cmd_valid` input 1 — command present on `cmd_*`.
- `cmd_ready` output 1 — FIFO can accept a command.
- `cmd_op` input 2 — 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- `cmd_data` input 4 — parallel load value.
- `cmd_sin` input 8 — serial bit per step, bit k used on step k.
- `cmd_cnt` input 3 — step count minus one (0 → 1 step, 7 → 8 steps).
- `mode` output 2 — to shift register `mode`.
- `data_in` output 4 — to shift register `data_in`.
- `serial_in` output 1 — to shift register `serial_in`.
- `busy` output 1 — FSM in EXEC or FIFO non-empty.
- `done` output 1 — one-cycle pulse on the last step of each command.
- `shadow_q` output 4 — predicted shift register contents (see Configuration).

## Operation
- FIFO write when `cmd_valid && cmd_ready`; `cmd_ready = !full`. No bypass: a push when full is ignored even if a pop occurs that cycle.
- FSM states IDLE, EXEC; step counter `step[2:0]`.
- IDLE: `mode=00`, `data_in=0`, `serial_in=0`. If FIFO non-empty, pop head, latch op/data/sin/cnt, `step=0`, go EXEC.
- EXEC: `mode=op`, `data_in=data`, `serial_in=sin[step]`. Each cycle `step` increments. When `step==cnt`, assert `done`. Then pop the next command if available (back-to-back, no idle cycle, `step=0`), otherwise return to IDLE.
- `data_in` is driven with the latched value for all ops, not only load.
- FIFO pointers wrap modulo DEPTH; full/empty are distinguished with an extra pointer bit.

## Timing
- All outputs registered.
- Command accepted at edge N into an empty, idle block: first step is visible on `mode`/`data_in`/`serial_in` after edge N+1. The shift register samples it at edge N+2.
- A command occupies exactly `cnt+1` consecutive cycles. `done` is high during the last of them.
- Back-to-back commands: the first step of the next command follows the `done` cycle directly.
- Reset (any cycle, including mid-command): FIFO emptied, state IDLE, `step=0`, `mode=00`, `data_in=0000`, `serial_in=0`, `done=0`, `busy=0`, `shadow_q=0000`. `cmd_ready=0` while `rst` is high and 1 on the first cycle after. The in-flight command is discarded with no `done`.
- `busy` deasserts the cycle after the final `done` when the FIFO is empty.

## Configuration
- Macro `USR_SEQ_SHADOW_EN`.
- Defined: `shadow_q` updates at each edge where an EXEC step is applied to the register, using the register semantics:
  - hold: unchanged
  - shift right: `{serial_in, q[3:1]}`
  - shift left: `{q[2:0], serial_in}`
  - load: `data_in`
  
  `shadow_q` therefore equals the register's `data_out` one cycle after each step. It holds its value in IDLE.
- Undefined: no shadow logic; `shadow_q` tied to `4'b0000`; port retained.

## Test plan
- Reset then a single command op=11, data=1010, cnt=0 → `mode=11`, `data_in=1010` for one cycle, two edges after acceptance; `done` in the same cycle; shadow 1010.
- Load 1010, then op=01, sin=8'b0000_0001, cnt=1 → `serial_in` 1 then 0 on consecutive cycles, no gap between commands; shadow 1101 then 0110.
- op=10, sin=8'b0000_0011, cnt=3 following load 0000 → four cycles of `mode=10`, `serial_in` 1,1,0,0; a single `done`; shadow ends 1100.
- Push 5 commands with DEPTH=4 while the first executes → `cmd_ready` low when the FIFO holds 4; all accepted commands execute in order; `busy` drops only after the last `done`.
- Assert `rst` in the middle of a cnt=7 shift → outputs 0 the cycle after, FIFO empty, no `done`, `cmd_ready` returns 1 after release.
- Hold command, cnt=2 → `mode=00` for 3 cycles; shadow unchanged; `done` on the third cycle.
